fb_qspi_responder: RTL and testbench
====================================

FB_QSPI_RESPONDER -- requirements
Module: fb_qspi_responder

Interface
REQ-001 Parameter DEPTH, default 1024: framebuffer depth in 4-bit pixels, any value >= 2.
REQ-002 Parameter ADDR_W, default $clog2(DEPTH): pointer width.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ctrl_in  input  8  control byte from the framebuffer reader: {read, reset_read_ptr, reset_write_ptr, write_strobe, write_pixel[3:0]} (MSB first).
REQ-006 data_out  output  4  registered pixel returned to the reader.
REQ-007 wr_wrap  output  1  sticky flag: write pointer wrapped (see Configuration).
REQ-008 rd_ptr_o, wr_ptr_o  output  ADDR_W each  current pointers, for observation only.

Function
REQ-009 ctrl_in is synchronous to clk; it is sampled every cycle with no synchronizer.
REQ-010 Read: if read=1 in cycle k, then data_out equals mem[rd_ptr] from edge k onward and holds until the next read; rd_ptr increments by 1 at the same edge.
REQ-011 Read latency is exactly one cycle, so that a reader registering data one cycle after asserting read captures the addressed pixel.
REQ-012 data_out holds its last value on cycles with read=0.
REQ-013 reset_read_ptr=1 (level) forces rd_ptr to 0 every cycle it is high; it has priority over increment.
REQ-014 read=1 together with reset_read_ptr=1 returns mem[0], and rd_ptr stays 0.
REQ-015 Write: a rising edge of write_strobe (0 in cycle k-1, 1 in cycle k) writes write_pixel to mem[wr_ptr] at edge k, and wr_ptr increments by 1.
REQ-016 A write_strobe level held high produces exactly one write.
REQ-017 reset_write_ptr=1 (level) forces wr_ptr to 0; a strobe edge in the same cycle is dropped and does not write.
REQ-018 Both pointers wrap from DEPTH-1 to 0.
REQ-019 Read and write to the same address in the same cycle return the old contents (read-before-write).
REQ-020 Read and write operate independently and may occur in the same cycle.

Reset
REQ-021 While rst_n=0: rd_ptr=0, wr_ptr=0, data_out=0, wr_wrap=0, and the strobe-edge history register=0.
REQ-022 Memory contents are not reset and are preserved across rst_n.
REQ-023 Strobe and read activity while rst_n=0 is ignored.
REQ-024 A strobe already high when rst_n deasserts produces a write on the first cycle out of reset.

Configuration
REQ-025 Macro FB_RESPONDER_WRAP_FLAG_EN.
  - Defined: wr_wrap sets to 1 at the edge where wr_ptr wraps from DEPTH-1 to 0 through a write.
  - Defined: wr_wrap clears on reset_write_ptr=1 or rst_n=0; set has priority over clear only if both occur in the same cycle without reset_write_ptr.
  - Not defined: wr_wrap is constant 0 and no flag logic is synthesized.

Structure
REQ-026 Shared package fb_pkg holds the ctrl bit-index constants (CTRL_READ=7, CTRL_RST_RD=6, CTRL_RST_WR=5, CTRL_WSTB=4, CTRL_PIX_LSB=0) and the pixel width constant PIX_W=4; the reader and this block both use them.
REQ-027 Sub-module fb_mem: a DEPTH x PIX_W simple dual-port RAM with synchronous write and a registered read port with read-enable; the pointer and strobe logic stays in fb_qspi_responder.

Verification
REQ-028 Reset, then write pixels 0x1,0x2,0x3 via three strobe pulses, then reset_read_ptr pulse, then read three consecutive cycles -> data_out = 0x1,0x2,0x3 on the three cycles following each read; rd_ptr_o=3.
REQ-029 write_strobe held high for 5 cycles with pixel 0xA -> exactly one write; wr_ptr_o advances by 1.
REQ-030 DEPTH=4: 5 writes of 0x5,0x6,0x7,0x8,0x9 -> mem[0]=0x9, wr_ptr_o=1; with the macro defined, wr_wrap=1 after the 4th write; a reset_write_ptr pulse clears it.
REQ-031 reset_write_ptr=1 in the same cycle as a strobe edge with pixel 0xF -> no write; wr_ptr_o=0; mem[0] unchanged.
REQ-032 Read and write to address 2 in the same cycle (old value 0x3, new value 0xC) -> data_out=0x3; a later read of address 2 returns 0xC.
REQ-033 Connect to the VGA framebuffer reader with a 640x480 timing scaled to a small DEPTH, prefilled with a ramp -> gray_out reproduces the ramp on each visible line, and rd_ptr_o resets to 0 during v_sync.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: control-byte bit positions, pixel width,
// and a decoder used by both the framebuffer reader and the responder.
package fb_pkg;

   localparam int PIX_W        = 4;
   localparam int CTRL_READ    = 7;
   localparam int CTRL_RST_RD  = 6;
   localparam int CTRL_RST_WR  = 5;
   localparam int CTRL_WSTB    = 4;
   localparam int CTRL_PIX_LSB = 0;

   typedef struct packed {
      logic             read;
      logic             rst_rd;
      logic             rst_wr;
      logic             wstb;
      logic [PIX_W-1:0] pix;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [7:0] c);
      ctrl_t d;
      d.read   = c[CTRL_READ];
      d.rst_rd = c[CTRL_RST_RD];
      d.rst_wr = c[CTRL_RST_WR];
      d.wstb   = c[CTRL_WSTB];
      d.pix    = c[CTRL_PIX_LSB +: PIX_W];
      return d;
   endfunction

endpackage

// File: rtl/fb_mem.sv
// DEPTH x PIX_W simple dual-port pixel RAM: synchronous write, registered
// read with read-enable; a same-address read and write returns the old pixel.
module fb_mem
   import fb_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [PIX_W-1:0]  i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [PIX_W-1:0]  o_rdata
);

   logic [PIX_W-1:0] r_mem [DEPTH];
   logic [PIX_W-1:0] r_rdata;

   // NOTE: the array has no reset so it maps onto block RAM and keeps its
   // contents across rst_n; only the output register is cleared.
   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_rdata <= '0;
      else if (i_re)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/fb_qspi_responder.sv
// Framebuffer responder: pointer, strobe-edge and wrap-flag logic around fb_mem.
// Optional feature macro: FB_RESPONDER_WRAP_FLAG_EN (sticky write-wrap flag).
module fb_qspi_responder
   import fb_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        ctrl_in,
   output logic [PIX_W-1:0]  data_out,
   output logic              wr_wrap,
   output logic [ADDR_W-1:0] rd_ptr_o,
   output logic [ADDR_W-1:0] wr_ptr_o
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   ctrl_t             w_ctrl;
   logic              w_we;
   logic              w_re;
   logic [ADDR_W-1:0] w_raddr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic              r_wstb_q;

   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == LAST) ? '0 : p + ADDR_W'(1);
   endfunction

   assign w_ctrl  = decode_ctrl(ctrl_in);
   // A strobe edge coinciding with reset_write_ptr is dropped.
   assign w_we    = rst_n & w_ctrl.wstb & ~r_wstb_q & ~w_ctrl.rst_wr;
   assign w_re    = rst_n & w_ctrl.read;
   assign w_raddr = w_ctrl.rst_rd ? '0 : r_rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_wstb_q <= 1'b0;
      end else begin
         r_wstb_q <= w_ctrl.wstb;

         if (w_ctrl.rst_rd)
            r_rd_ptr <= '0;
         else if (w_ctrl.read)
            r_rd_ptr <= ptr_inc(r_rd_ptr);

         if (w_ctrl.rst_wr)
            r_wr_ptr <= '0;
         else if (w_we)
            r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
   end

`ifdef FB_RESPONDER_WRAP_FLAG_EN
   logic r_wr_wrap;

   always_ff @(posedge clk) begin
      if (!rst_n || w_ctrl.rst_wr)
         r_wr_wrap <= 1'b0;
      else if (w_we && (r_wr_ptr == LAST))
         r_wr_wrap <= 1'b1;
   end

   assign wr_wrap = r_wr_wrap;
`else
   assign wr_wrap = 1'b0;
`endif

   fb_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_ctrl.pix),
      .i_re    (w_re),
      .i_raddr (w_raddr),
      .o_rdata (data_out)
   );

   assign rd_ptr_o = r_rd_ptr;
   assign wr_ptr_o = r_wr_ptr;

endmodule

// File: tb/tb_fb_qspi_responder.sv
// Directed bench for fb_qspi_responder at DEPTH=4; read data is checked by a
// scoreboard monitor, pointers and flags by inline checks.
module tb_fb_qspi_responder;

   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);
`ifdef FB_RESPONDER_WRAP_FLAG_EN
   localparam logic WRAP_EN = 1'b1;
`else
   localparam logic WRAP_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic [7:0]    ctrl_in;
   logic [3:0]    data_out;
   logic          wr_wrap;
   logic [AW-1:0] rd_ptr_o;
   logic [AW-1:0] wr_ptr_o;

   fb_qspi_responder #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ctrl_in  (ctrl_in),
      .data_out (data_out),
      .wr_wrap  (wr_wrap),
      .rd_ptr_o (rd_ptr_o),
      .wr_ptr_o (wr_ptr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [3:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] c(input bit rd, input bit rrd, input bit rwr,
                                    input bit wstb, input logic [3:0] pix);
      return {rd, rrd, rwr, wstb, pix};
   endfunction

   task automatic step(input logic [7:0] v, input int n = 1);
      repeat (n) begin
         ctrl_in = v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_read(input logic [3:0] e, input bit rrd = 1'b0);
      exp_q.push_back(e);
      step(c(1, rrd, 0, 0, 4'h0));
   endtask

   task automatic write_px(input logic [3:0] p);
      step(c(0, 0, 0, 1, p));
      step(8'h00);
   endtask

   // Scoreboard monitor: every accepted read owes one data_out value after its edge.
   initial begin
      logic rd_seen;
      logic [3:0] e;
      forever begin
         @(posedge clk);
         rd_seen = rst_n & ctrl_in[7];
         @(negedge clk);
         if (rd_seen) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("data_out", {28'd0, data_out}, {28'd0, e});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset with read and strobe activity that must be ignored
      rst_n   = 1'b0;
      ctrl_in = 8'h00;
      step(c(1, 0, 0, 1, 4'h5), 3);
      check("rst_rd_ptr", rd_ptr_o, 0);
      check("rst_wr_ptr", wr_ptr_o, 0);
      check("rst_data_out", data_out, 0);
      check("rst_wr_wrap", wr_wrap, 0);
      rst_n = 1'b1;
      step(8'h00);
      check("post_rst_wr_ptr", wr_ptr_o, 0);

      // Three writes, rewind, three reads
      write_px(4'h1);
      write_px(4'h2);
      write_px(4'h3);
      check("wr_ptr_after_3", wr_ptr_o, 3);
      step(c(0, 1, 0, 0, 4'h0));
      push_read(4'h1);
      push_read(4'h2);
      push_read(4'h3);
      step(8'h00);
      check("rd_ptr_after_3", rd_ptr_o, 3);
      check("data_hold", data_out, 4'h3);

      // reset_write_ptr with a strobe edge: dropped; read+rewind returns mem[0]
      step(c(0, 0, 1, 1, 4'hF));
      check("rwr_drop_wr_ptr", wr_ptr_o, 0);
      step(8'h00);
      push_read(4'h1, 1'b1);
      check("read_rewind_rd_ptr", rd_ptr_o, 0);

      // Same-cycle read and write at address 2 (old 0x3, new 0xC)
      write_px(4'h1);
      write_px(4'h2);
      push_read(4'h1);
      push_read(4'h2);
      exp_q.push_back(4'h3);
      step(c(1, 0, 0, 1, 4'hC));
      step(8'h00);
      step(c(0, 1, 0, 0, 4'h0));
      push_read(4'h1);
      push_read(4'h2);
      push_read(4'hC);
      check("rw_same_wr_ptr", wr_ptr_o, 3);

      // Strobe held high for 5 cycles: one write at address 3
      step(c(0, 0, 0, 1, 4'hA), 5);
      check("held_strobe_wr_ptr", wr_ptr_o, 0);
      check("held_strobe_wrap", wr_wrap, WRAP_EN);
      step(8'h00);
      push_read(4'hA);
      push_read(4'h1);
      step(c(0, 0, 1, 0, 4'h0));
      check("wrap_cleared", wr_wrap, 0);
      step(8'h00);

      // Five writes through DEPTH=4
      write_px(4'h5);
      write_px(4'h6);
      write_px(4'h7);
      check("wrap_before_4th", wr_wrap, 0);
      write_px(4'h8);
      check("wrap_after_4th", wr_wrap, WRAP_EN);
      check("wr_ptr_after_4th", wr_ptr_o, 0);
      write_px(4'h9);
      check("wr_ptr_after_5th", wr_ptr_o, 1);
      step(c(0, 1, 0, 0, 4'h0));
      push_read(4'h9);
      push_read(4'h6);
      push_read(4'h7);
      push_read(4'h8);
      check("rd_ptr_wrapped", rd_ptr_o, 0);
      step(c(0, 0, 1, 0, 4'h0));
      check("wrap_pulse_clear", wr_wrap, 0);
      check("wr_ptr_pulse_clear", wr_ptr_o, 0);
      step(8'h00);

      // Strobe high across reset release writes on first cycle out; memory kept
      rst_n = 1'b0;
      step(c(1, 0, 0, 1, 4'hB), 3);
      check("rst2_rd_ptr", rd_ptr_o, 0);
      check("rst2_data_out", data_out, 0);
      rst_n = 1'b1;
      step(c(0, 0, 0, 1, 4'hB));
      check("strobe_at_release", wr_ptr_o, 1);
      step(8'h00);
      push_read(4'hB);
      push_read(4'h6);

      // Scaled reader frames: ramp line, rewind during v_sync
      step(c(0, 0, 1, 0, 4'h0));
      step(8'h00);
      for (int p = 0; p < DEPTH; p++) write_px(4'(p));
      for (int f = 0; f < 2; f++) begin
         step(c(0, 1, 0, 0, 4'h0), 2);
         check("vsync_rd_ptr", rd_ptr_o, 0);
         for (int ln = 0; ln < 2; ln++) begin
            for (int p = 0; p < DEPTH; p++) push_read(4'(p));
            step(8'h00, 2);
            check("line_end_rd_ptr", rd_ptr_o, 0);
         end
      end

      step(8'h00, 3);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
